// File: rtl/fake_signal_gen.sv
// rtl/fake_signal_gen.sv - fake pulse / ramp injector with equal-latency pass-through
//
// Sits between ADC capture and the filter/trigger chain. Every channel goes
// through two register stages; masked channels get a synthetic {HG, LG}
// sample instead of the delayed ADC word, so all channels stay aligned.
//
// Optional feature macro: FAKE_SIGNAL_MUON_EN (adds MUON_PERIOD input and a
// periodic 4-cycle muon pulse summed into the pulse value in modes 1 and 2).
//
// Ports:
//   CLK, RST_N    clock, asynchronous active-low reset
//   ENABLE        0 = pure pass-through, pulse FSM held idle
//   MODE          0 off, 1 periodic, 2 random interval, 3 ramp
//   CH_MASK       per-channel fake-signal select
//   PERIOD        base gap length in cycles
//   WIDTH         pulse length in cycles
//   AMPLITUDE     pulse height above pedestal (HG units)
//   RAND_BITS     number of LFSR bits added to PERIOD in mode 2
//   MUON_PERIOD   muon spacing (only with FAKE_SIGNAL_MUON_EN)
//   ADC_IN        packed channels, ch0 in LSBs, HG in upper half of each word
//   ADC_OUT       same packing, two cycles after ADC_IN
//   PULSE_ACTIVE  high while a fake pulse is on ADC_OUT
//   PULSE_COUNT   pulses generated since reset (wraps), aligned with ADC_OUT
module fake_signal_gen #(
  parameter int          NCH       = 5,
  parameter int          SAMPLE_W  = 12,
  parameter int          PEDESTAL  = 200,
  parameter int          LG_SHIFT  = 5,
  parameter int          DLY_W     = 32,
  parameter logic [31:0] LFSR_SEED = 32'h0000000F
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      ENABLE,
  input  logic [1:0]                MODE,
  input  logic [NCH-1:0]            CH_MASK,
  input  logic [DLY_W-1:0]          PERIOD,
  input  logic [15:0]               WIDTH,
  input  logic [SAMPLE_W-1:0]       AMPLITUDE,
  input  logic [4:0]                RAND_BITS,
`ifdef FAKE_SIGNAL_MUON_EN
  input  logic [DLY_W-1:0]          MUON_PERIOD,
`endif
  input  logic [NCH*2*SAMPLE_W-1:0] ADC_IN,
  output logic [NCH*2*SAMPLE_W-1:0] ADC_OUT,
  output logic                      PULSE_ACTIVE,
  output logic [31:0]               PULSE_COUNT
);

  localparam int CHW = 2 * SAMPLE_W;
  localparam int CW  = (DLY_W > 16) ? DLY_W : 16;
  // Two bits of headroom so pulse + muon + pedestal never wraps before saturation.
  localparam int PW  = SAMPLE_W + 2;
  localparam logic [PW-1:0] SAT  = PW'({SAMPLE_W{1'b1}});
  localparam logic [31:0]   POLY = 32'h80200003;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_PULSE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [1:0]            mode_q;
  logic [31:0]           lfsr;
  logic [31:0]           pulse_cnt;
  logic [SAMPLE_W-2:0]   ramp;

  logic                  run_mode;
  logic                  ramp_on;
  logic                  restart;
  logic                  pulse_on;
  logic [31:0]           rand_mask;
  logic [DLY_W-1:0]      gap_sum;
  logic [CW-1:0]         gap_len;
  logic [CW-1:0]         pulse_len;
  logic [PW-1:0]         muon_p;
  logic [PW-1:0]         p_now;

  assign run_mode = ENABLE && (MODE == 2'd1 || MODE == 2'd2);
  assign ramp_on  = ENABLE && (MODE == 2'd3);
  // A mode change only needs a restart once the FSM has left IDLE.
  assign restart  = !run_mode || (state != S_IDLE && MODE != mode_q);
  assign pulse_on = run_mode && (state == S_PULSE);

  always_comb begin
    // RAND_BITS is 5 bits wide, so the mask never needs the full-width case.
    rand_mask = (32'd1 << RAND_BITS) - 32'd1;
    gap_sum   = PERIOD;
    if (MODE == 2'd2)
      gap_sum = PERIOD + DLY_W'(lfsr & rand_mask);
    gap_len   = (gap_sum == '0) ? CW'(1) : CW'(gap_sum);
    pulse_len = (WIDTH == 16'd0) ? CW'(1) : CW'(WIDTH);
  end

  // Pulse FSM; cnt holds the cycles remaining in the current GAP/PULSE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_q    <= 2'd0;
      pulse_cnt <= '0;
    end else begin
      mode_q <= MODE;
      if (restart) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_GAP;
            cnt   <= gap_len;
          end
          S_GAP: begin
            if (cnt <= CW'(1)) begin
              state     <= S_PULSE;
              cnt       <= pulse_len;
              pulse_cnt <= pulse_cnt + 32'd1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_PULSE: begin
            if (cnt <= CW'(1)) begin
              state <= S_GAP;
              cnt   <= gap_len;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Galois LFSR x^32+x^22+x^2+x+1; a zero state would lock up, so reseed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      lfsr <= LFSR_SEED;
    else if (ENABLE) begin
      if (lfsr == 32'd0)
        lfsr <= LFSR_SEED;
      else
        lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'd0);
    end
  end

  // Ramp restarts from zero every time mode 3 is entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      ramp <= '0;
    else if (ramp_on)
      ramp <= ramp + 1'b1;
    else
      ramp <= '0;
  end

`ifdef FAKE_SIGNAL_MUON_EN
  localparam int MW = DLY_W + 1;
  logic [MW-1:0] muon_cnt;
  logic [MW-1:0] muon_len;

  assign muon_len = (MUON_PERIOD == '0) ? MW'(1) : {1'b0, MUON_PERIOD};

  // Counts 0 .. len+3; the last four counts are the muon pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      muon_cnt <= '0;
    else if (!run_mode || MODE != mode_q)
      muon_cnt <= '0;
    else if (muon_cnt >= muon_len + MW'(3))
      muon_cnt <= '0;
    else
      muon_cnt <= muon_cnt + MW'(1);
  end

  assign muon_p = (run_mode && muon_cnt >= muon_len) ? PW'(AMPLITUDE >> 2) : '0;
`else
  assign muon_p = '0;
`endif

  always_comb begin
    p_now = '0;
    if (pulse_on)
      p_now = PW'(AMPLITUDE);
    else if (ramp_on)
      p_now = PW'(ramp);
    p_now = p_now + muon_p;
  end

  // Stage 1: capture ADC data together with every control that steers stage 2.
  logic [NCH*CHW-1:0] adc_d1;
  logic [PW-1:0]      p_d1;
  logic               act_d1;
  logic               fake_d1;
  logic [NCH-1:0]     mask_d1;
  logic [31:0]        cnt_d1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      adc_d1  <= '0;
      p_d1    <= '0;
      act_d1  <= 1'b0;
      fake_d1 <= 1'b0;
      mask_d1 <= '0;
      cnt_d1  <= '0;
    end else begin
      adc_d1  <= ADC_IN;
      p_d1    <= p_now;
      act_d1  <= pulse_on;
      fake_d1 <= ENABLE && (MODE != 2'd0);
      mask_d1 <= CH_MASK;
      cnt_d1  <= pulse_cnt;
    end
  end

  logic [PW-1:0]       hg_sum;
  logic [PW-1:0]       lg_sum;
  logic [SAMPLE_W-1:0] hg;
  logic [SAMPLE_W-1:0] lg;

  always_comb begin
    hg_sum = p_d1 + PW'(PEDESTAL);
    lg_sum = (p_d1 >> LG_SHIFT) + PW'(PEDESTAL);
    hg     = (hg_sum > SAT) ? {SAMPLE_W{1'b1}} : hg_sum[SAMPLE_W-1:0];
    lg     = (lg_sum > SAT) ? {SAMPLE_W{1'b1}} : lg_sum[SAMPLE_W-1:0];
  end

  // Stage 2: per-channel select between fake sample and delayed ADC word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ADC_OUT      <= '0;
      PULSE_ACTIVE <= 1'b0;
      PULSE_COUNT  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (fake_d1 && mask_d1[i])
          ADC_OUT[i*CHW +: CHW] <= {hg, lg};
        else
          ADC_OUT[i*CHW +: CHW] <= adc_d1[i*CHW +: CHW];
      end
      PULSE_ACTIVE <= act_d1;
      PULSE_COUNT  <= cnt_d1;
    end
  end

endmodule

// File: tb/tb_fake_signal_gen.sv
// tb/tb_fake_signal_gen.sv - scoreboard bench for fake_signal_gen
module tb_fake_signal_gen;

  localparam int          NCH   = 5;
  localparam int          SW    = 12;
  localparam int          CHW   = 2 * SW;
  localparam int          ADC_W = NCH * CHW;
  localparam logic [31:0] SEED  = 32'h0000000F;
  localparam int          NS    = 600;

  localparam logic [23:0] W_BASE  = 24'h0C80C8;
  localparam logic [23:0] W_PULSE = 24'h4B00E7;
  localparam logic [23:0] W_SAT   = 24'hFFF145;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             ENABLE = 1'b0;
  logic [1:0]       MODE = 2'd0;
  logic [NCH-1:0]   CH_MASK = '1;
  logic [31:0]      PERIOD = 32'd0;
  logic [15:0]      WIDTH = 16'd0;
  logic [SW-1:0]    AMPLITUDE = '0;
  logic [4:0]       RAND_BITS = 5'd0;
  logic [ADC_W-1:0] ADC_IN = '0;
  logic [ADC_W-1:0] ADC_OUT;
  logic             PULSE_ACTIVE;
  logic [31:0]      PULSE_COUNT;
`ifdef FAKE_SIGNAL_MUON_EN
  logic [31:0]      MUON_PERIOD = '1;
`endif

  fake_signal_gen dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ENABLE       (ENABLE),
    .MODE         (MODE),
    .CH_MASK      (CH_MASK),
    .PERIOD       (PERIOD),
    .WIDTH        (WIDTH),
    .AMPLITUDE    (AMPLITUDE),
    .RAND_BITS    (RAND_BITS),
`ifdef FAKE_SIGNAL_MUON_EN
    .MUON_PERIOD  (MUON_PERIOD),
`endif
    .ADC_IN       (ADC_IN),
    .ADC_OUT      (ADC_OUT),
    .PULSE_ACTIVE (PULSE_ACTIVE),
    .PULSE_COUNT  (PULSE_COUNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [ADC_W-1:0] adc;
    logic             act;
    logic [31:0]      cnt;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected schedule for modes 1/2, indexed by cycle relative to the first enabled cycle.
  bit          s_pulse[NS];
  int          s_cnt[NS];
  logic [31:0] s_lfsr[NS];

  // Monitor: compare every expectation due in this cycle.
  exp_t m;
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      n_checks++;
      if (m.cyc != cyc || ADC_OUT !== m.adc || PULSE_ACTIVE !== m.act || PULSE_COUNT !== m.cnt) begin
        n_fail++;
        $display("FAIL %s cyc=%0d(due %0d): adc=%h act=%b cnt=%0d, required adc=%h act=%b cnt=%0d",
                 m.tag, cyc, m.cyc, ADC_OUT, PULSE_ACTIVE, PULSE_COUNT, m.adc, m.act, m.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [ADC_W-1:0] adc, input logic act, input logic [31:0] cnt,
                      input string tag);
    exp_t e;
    e.cyc = cyc + 2;
    e.adc = adc;
    e.act = act;
    e.cnt = cnt;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Reset for one cycle: pending expectations are void, outputs read zero
  // for this cycle and the two that follow.
  task automatic do_reset();
    exp_t e;
    while (sb.size() > 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
    RST_N = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e.cyc = cyc + k;
      e.adc = '0;
      e.act = 1'b0;
      e.cnt = 32'd0;
      e.tag = "reset";
      sb.push_back(e);
    end
    tick();
    RST_N = 1'b1;
  endtask

  function automatic logic [ADC_W-1:0] rand_adc();
    logic [ADC_W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*CHW +: CHW] = CHW'($urandom);
    return r;
  endfunction

  function automatic logic [ADC_W-1:0] mix(input logic [ADC_W-1:0] a, input logic [NCH-1:0] msk,
                                           input logic [23:0] w);
    logic [ADC_W-1:0] r;
    r = a;
    for (int i = 0; i < NCH; i++) if (msk[i]) r[i*CHW +: CHW] = w;
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] n;
    if (v == 32'd0) return SEED;
    n = {1'b0, v[31:1]};
    if (v[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // Builds the pulse timeline: first GAP starts at rel cycle s0; each gap length
  // uses the LFSR value of the cycle just before that gap.
  task automatic gen_sched(input int period, input int width, input int rb, input int s0);
    logic [31:0] v;
    int s, g, e, n, w;
    v = SEED;
    for (int i = 0; i < NS; i++) begin
      s_lfsr[i]  = v;
      v          = lfsr_step(v);
      s_pulse[i] = 1'b0;
      s_cnt[i]   = 0;
    end
    w = (width == 0) ? 1 : width;
    s = s0;
    e = s0 - 1;
    n = 0;
    while (s < NS) begin
      g = period + ((rb == 0) ? 0 : int'(s_lfsr[e] & ((32'd1 << rb) - 32'd1)));
      if (g == 0) g = 1;
      for (int i = s; i < s + g && i < NS; i++) s_cnt[i] = n;
      n++;
      for (int i = s + g; i < s + g + w && i < NS; i++) begin
        s_pulse[i] = 1'b1;
        s_cnt[i]   = n;
      end
      e = s + g + w - 1;
      s = s + g + w;
    end
  endtask

  task automatic run_sched(input int i0, input int i1, input logic [23:0] pw, input string tag);
    logic [ADC_W-1:0] a;
    for (int i = i0; i < i1; i++) begin
      a      = rand_adc();
      ADC_IN = a;
      push(mix(a, CH_MASK, s_pulse[i] ? pw : W_BASE), s_pulse[i], s_cnt[i], tag);
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADC_W-1:0] a;
    int r;

    // Pass-through: disabled, then enabled with MODE=0.
    ENABLE = 1'b0;
    MODE   = 2'd1;
    tick();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        ENABLE = 1'b1;
        MODE   = 2'd0;
      end
      a      = (i == 0) ? {NCH{24'h123456}} : rand_adc();
      ADC_IN = a;
      push(a, 1'b0, 32'd0, (i < 8) ? "pass_dis" : "pass_mode0");
      tick();
    end

    // Periodic mode, all channels.
    ENABLE = 1'b1; MODE = 2'd1; PERIOD = 10; WIDTH = 3; AMPLITUDE = 12'd1000;
    RAND_BITS = 5'd0; CH_MASK = 5'b11111;
    do_reset();
    gen_sched(10, 3, 0, 1);
    run_sched(0, 45, W_PULSE, "mode1");

    // Saturation and partial mask.
    AMPLITUDE = 12'd4000; CH_MASK = 5'b00101;
    do_reset();
    gen_sched(10, 3, 0, 1);
    run_sched(0, 45, W_SAT, "sat_mask");

    // Random-interval mode.
    MODE = 2'd2; PERIOD = 100; RAND_BITS = 5'd4; AMPLITUDE = 12'd1000; CH_MASK = 5'b11111;
    do_reset();
    gen_sched(100, 3, 4, 1);
    run_sched(0, 500, W_PULSE, "mode2");

    // Ramp mode across the wrap point.
    MODE = 2'd3; CH_MASK = 5'b11011;
    do_reset();
    for (int i = 0; i < 2060; i++) begin
      r      = i % 2048;
      a      = rand_adc();
      ADC_IN = a;
      push(mix(a, CH_MASK, {12'(r + 200), 12'((r >> 5) + 200)}), 1'b0, 32'd0, "ramp");
      tick();
    end

    // Reset mid-pulse, then mode 1 -> 2 mid-gap.
    MODE = 2'd1; PERIOD = 10; WIDTH = 3; RAND_BITS = 5'd0; CH_MASK = 5'b11111;
    do_reset();
    gen_sched(10, 3, 0, 1);
    run_sched(0, 12, W_PULSE, "pre_reset");
    do_reset();
    gen_sched(10, 3, 0, 1);
    run_sched(0, 6, W_PULSE, "post_reset");
    MODE = 2'd2; RAND_BITS = 5'd4;
    gen_sched(10, 3, 4, 8);
    run_sched(6, 200, W_PULSE, "mode_change");

    ENABLE = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
